uart_rx_fifo: RTL and testbench

- UART receiver for the SoC, 8N1, LSB first: the inbound partner of the existing uart_tx path.
- Samples the asynchronous serial input at the bit midpoint using a clock divider.
- Buffers received bytes in a show-ahead FIFO read by the CPU bus glue.
- Reports framing errors and overruns as sticky flags.

---
 rtl/uart_rx_fifo.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (LSB first, mid-bit sampling) feeding a show-ahead byte FIFO,
// with sticky framing-error and overrun flags.
module uart_rx_fifo #(
   parameter int CLK_HZ     = 25000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16,
   localparam int AW        = $clog2(FIFO_DEPTH)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          uart_rx,
   output logic [7:0]    rd_data,
   output logic          rd_valid,
   input  logic          rd_ack,
   output logic [AW:0]   fifo_count,
   output logic          frame_err,
   output logic          overrun,
   input  logic          err_clr,
   output logic [2:0]    dbg_state_o
);

   localparam int DIV  = CLK_HZ / BAUD;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV);

   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BRK   = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic          sync1_q, sync2_q;
   logic          rx_s;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          push;
   logic          frame_set;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          full;
   logic          pop;
   logic          push_ok;
   logic          ovr_set;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q, overrun_d;

   // Two-flop synchroniser; resets to the idle-high line level.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= uart_rx;
         sync2_q <= sync1_q;
      end
   end

   assign rx_s = sync2_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      push      = 1'b0;
      frame_set = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = ST_START;
         end
         ST_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               bit_d = '0;
               // A start bit that is high again at its midpoint was noise.
               state_d = rx_s ? ST_IDLE : ST_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = ST_STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  push    = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  frame_set = 1'b1;
                  state_d   = ST_BRK;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_BRK: begin
            // Hold off until the line recovers so a break yields no bytes.
            cnt_d = '0;
            if (rx_s) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Handshake: rd_valid means rd_data holds the head byte; the head is popped
   // on any rising edge where rd_ack=1 and rd_valid=1 (rd_ack is ignored otherwise).
   assign full    = (count_q == CNT_FULL);
   assign pop     = rd_ack && (count_q != '0);
   assign push_ok = push && (!full || pop);
   assign ovr_set = push && full && !pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push_ok, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else if (push_ok) begin
         mem_q[wr_ptr_q] <= shift_q;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Set events take priority over a simultaneous clear.
   always_comb begin
      frame_err_d = frame_err_q;
      overrun_d   = overrun_q;
      if (err_clr) begin
         frame_err_d = 1'b0;
         overrun_d   = 1'b0;
      end
      if (frame_set) frame_err_d = 1'b1;
      if (ovr_set)   overrun_d   = 1'b1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rd_data     = mem_q[rd_ptr_q];
   assign rd_valid    = (count_q != '0);
   assign fifo_count  = count_q;
   assign frame_err   = frame_err_q;
   assign overrun     = overrun_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised bench for uart_rx_fifo: a FIFO/flag reference model fed by the
// frame driver, and an independent monitor checking every popped byte.
module tb_uart_rx_fifo;

   localparam int CLK_HZ = 1843200;
   localparam int BAUD   = 115200;
   localparam int DEPTH  = 4;
   localparam int BIT_T  = CLK_HZ / BAUD;
   localparam int ST_IDLE = 0;

   logic       clk;
   logic       rst;
   logic       uart_rx;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_ack;
   logic [2:0] fifo_count;
   logic       frame_err;
   logic       overrun;
   logic       err_clr;
   logic [2:0] dbg_state;

   logic [7:0] exp_q[$];
   bit         exp_ferr;
   bit         exp_ovr;
   int         checks;
   int         errors;

   uart_rx_fifo #(
      .CLK_HZ    (CLK_HZ),
      .BAUD      (BAUD),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .CLK        (clk),
      .RST        (rst),
      .uart_rx    (uart_rx),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_ack     (rd_ack),
      .fifo_count (fifo_count),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .err_clr    (err_clr),
      .dbg_state_o(dbg_state)
   );

   // clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // monitor: every accepted pop must return the model's head byte
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rd_valid && rd_ack) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL pop_unexpected: got byte 0x%02h, expected an empty FIFO", rd_data);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if (rd_data !== e) begin
                  errors++;
                  $display("FAIL pop_data: got 0x%02h, expected 0x%02h", rd_data, e);
               end
            end
         end
      end
   end

   // driver tasks: entered and left on a falling clock edge
   task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit ack_at_push);
      uart_rx = 1'b0;
      repeat (BIT_T) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (BIT_T) @(negedge clk);
      end
      uart_rx = stop_ok;
      for (int j = 0; j < BIT_T; j++) begin
         @(negedge clk);
         if (ack_at_push && j == 9)  rd_ack = 1'b1;
         if (ack_at_push && j == 10) rd_ack = 1'b0;
      end
      if (stop_ok) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(b);
         else                      exp_ovr = 1'b1;
      end else begin
         exp_ferr = 1'b1;
      end
   endtask

   task automatic read_one();
      rd_ack = 1'b1;
      @(negedge clk);
      rd_ack = 1'b0;
   endtask

   task automatic clear_errs();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      exp_ferr = 1'b0;
      exp_ovr  = 1'b0;
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_count"},   int'(fifo_count), exp_q.size());
      chk({tag, "_valid"},   int'(rd_valid),   int'(exp_q.size() != 0));
      chk({tag, "_ferr"},    int'(frame_err),  int'(exp_ferr));
      chk({tag, "_overrun"}, int'(overrun),    int'(exp_ovr));
   endtask

   function automatic logic [7:0] rnd_byte();
      return 8'($urandom_range(0, 255));
   endfunction

   initial begin
      int         lat;
      bit         saw_valid;
      logic [7:0] rb;
      logic [7:0] b2b[4];
      checks   = 0;
      errors   = 0;
      exp_ferr = 1'b0;
      exp_ovr  = 1'b0;
      rst      = 1'b1;
      uart_rx  = 1'b1;
      rd_ack   = 1'b0;
      err_clr  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_data",  int'(rd_data),   0);
      chk("rst_state", int'(dbg_state), ST_IDLE);
      chk_state("rst");
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // 1: single byte, latency, pop
      lat = 0;
      fork
         send_byte(8'hA5, 1'b1, 1'b0);
         begin
            while (!rd_valid && lat < 400) begin
               @(negedge clk);
               lat++;
            end
         end
      join
      checks++;
      if (lat < 153 || lat > 157) begin
         errors++;
         $display("FAIL latency: got %0d cycles, expected 153..157", lat);
      end
      chk("t1_head", int'(rd_data), 8'hA5);
      chk_state("t1");
      read_one();
      chk_state("t1_pop");

      // 2: back-to-back frames, ordered reads, pointer wrap
      b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h55; b2b[3] = 8'h3C;
      for (int i = 0; i < 4; i++) send_byte(b2b[i], 1'b1, 1'b0);
      chk_state("t2_full");
      for (int i = 0; i < 4; i++) read_one();
      chk_state("t2_drained");
      for (int i = 0; i < 2; i++) begin
         send_byte(rnd_byte(), 1'b1, 1'b0);
         repeat ($urandom_range(0, 20)) @(negedge clk);
      end
      chk_state("t2_wrap");
      while (exp_q.size() != 0 && rd_valid) read_one();
      chk_state("t2_wrap_drained");

      // 3: overrun
      for (int i = 0; i < 5; i++) send_byte(rnd_byte(), 1'b1, 1'b0);
      chk_state("t3_overrun");
      clear_errs();
      chk_state("t3_cleared");
      for (int i = 0; i < 4; i++) read_one();
      chk_state("t3_drained");

      // 4: framing error followed by a long break
      send_byte(8'h81, 1'b0, 1'b0);
      saw_valid = 1'b0;
      repeat (40 * BIT_T) begin
         @(negedge clk);
         saw_valid |= rd_valid;
      end
      chk("t4_no_bytes_in_break", int'(saw_valid), 0);
      chk_state("t4_break");
      uart_rx = 1'b1;
      repeat (20) @(negedge clk);
      send_byte(8'h42, 1'b1, 1'b0);
      chk("t4_head", int'(rd_data), 8'h42);
      chk_state("t4_recv");
      read_one();
      clear_errs();
      chk_state("t4_cleared");

      // 5: glitch rejection, then reset in the middle of data bit 4
      uart_rx = 1'b0;
      repeat (5) @(negedge clk);
      uart_rx = 1'b1;
      repeat (30) @(negedge clk);
      chk("t5_glitch_state", int'(dbg_state), ST_IDLE);
      chk_state("t5_glitch");
      rb = rnd_byte();
      uart_rx = 1'b0;
      repeat (BIT_T) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         uart_rx = rb[i];
         repeat (BIT_T) @(negedge clk);
      end
      uart_rx = rb[4];
      repeat (BIT_T / 2) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      exp_ferr = 1'b0;
      exp_ovr  = 1'b0;
      #1;
      chk("t5_rst_state", int'(dbg_state), ST_IDLE);
      chk("t5_rst_data",  int'(rd_data),   0);
      chk_state("t5_rst");
      @(negedge clk);
      uart_rx = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (200) @(negedge clk);
      chk_state("t5_after_rst");
      send_byte(8'h7E, 1'b1, 1'b0);
      chk("t5_head", int'(rd_data), 8'h7E);
      chk_state("t5_recv");
      read_one();

      // 6: push and pop in the same cycle while full
      for (int i = 0; i < 4; i++) send_byte(rnd_byte(), 1'b1, 1'b0);
      chk_state("t6_full");
      send_byte(rnd_byte(), 1'b1, 1'b1);
      chk_state("t6_same_cycle");
      for (int i = 0; i < 4; i++) read_one();
      chk_state("t6_drained");

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
